// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, bit-timing constants and baud divider table
package uart_pkg;
  localparam int TICKS_PER_BIT = 16;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  // indexed by baud_select: round(50e6 / (16 * baud))
  localparam logic [7:0][13:0] BAUD_DIV = {
    14'd27, 14'd54, 14'd81, 14'd163, 14'd326, 14'd651, 14'd2604, 14'd10417
  };
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversampling tick, restarted whenever baud_select changes
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_tick
);
  logic [13:0] r_cnt;
  logic [2:0]  r_sel;
  logic        r_tick;
  logic        w_same;
  logic        w_last;
  assign w_same = baud_select == r_sel;
  assign w_last = r_cnt == BAUD_DIV[baud_select] - 14'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt  <= '0;
      r_sel  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_sel  <= baud_select;
      r_tick <= w_same && w_last;
      r_cnt  <= (!w_same || w_last) ? '0 : r_cnt + 14'd1;
    end
  assign sample_tick = r_tick;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8E1 UART receiver with 3-sample majority vote per bit
// UART_RX_NOISE_CHECK_EN: disagreeing mid-bit samples also flag a framing error
module uart_receiver
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       RX_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);
  state_t               r_state, w_next;
  logic [1:0]           r_sync;
  logic                 r_armed;
  logic [3:0]           r_cnt;
  logic [2:0]           r_bit;
  logic [1:0]           r_s;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 r_valid, r_perr, r_ferr;
  logic                 w_tick, w_rx, w_mid, w_end, w_bit, w_start, w_done, w_noise;

  uart_baud_gen u_baud (.clk, .reset, .baud_select, .sample_tick(w_tick));

  assign w_rx    = r_sync[1];
  assign w_mid   = w_tick && r_state != IDLE && r_cnt == 4'd9;
  assign w_end   = w_tick && r_cnt == 4'(TICKS_PER_BIT - 1);
  assign w_bit   = (r_s[1] & r_s[0]) | (r_s[1] & w_rx) | (r_s[0] & w_rx);
  assign w_start = r_state == IDLE && w_next == START;
  assign w_done  = w_end && r_state == STOP && RX_EN && !r_perr && !r_ferr;
`ifdef UART_RX_NOISE_CHECK_EN
  assign w_noise = !(r_s[1] == r_s[0] && r_s[0] == w_rx);
`else
  assign w_noise = 1'b0;
`endif

  // r_armed records that the line was high since the last start, so a start
  // edge landing while STOP is still finishing is not lost
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (r_armed && !w_rx) ? START : IDLE;
      START:   w_next = (w_tick && r_cnt == 4'd8 && w_rx) ? IDLE : w_end ? DATA : START;
      DATA:    w_next = (w_end && r_bit == 3'(DATA_BITS - 1)) ? PARITY : DATA;
      PARITY:  w_next = w_end ? STOP : PARITY;
      STOP:    w_next = w_end ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
    if (!RX_EN) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_sync  <= 2'b11;
      r_armed <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_s     <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], RxD};
      r_armed <= !w_start && (r_armed || w_rx);
      r_valid <= w_done;
      if (w_done) r_data <= r_shift;
      if (w_start) begin
        r_cnt  <= '0;
        r_bit  <= '0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else if (w_tick && r_state != IDLE) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd7 || r_cnt == 4'd8) r_s <= {r_s[0], w_rx};
        if (w_end && r_state == DATA) r_bit <= r_bit + 3'd1;
        if (w_mid) begin
          if (r_state == DATA) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
          r_perr <= r_perr | (r_state == PARITY && (w_bit ^ (^r_shift)));
          r_ferr <= r_ferr | w_noise | (r_state == STOP && !w_bit);
        end
      end
    end

  assign Rx_DATA   = r_data;
  assign Rx_VALID  = r_valid;
  assign Rx_PERROR = r_perr;
  assign Rx_FERROR = r_ferr;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames at 115200 baud, received bytes checked against a queue
module tb_uart_receiver;
  import uart_pkg::*;
  localparam int BIT = 432;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RX_EN = 1'b0;
  logic       RxD = 1'b1;
  logic [2:0] baud_select = 3'b111;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR;
  logic [7:0] exp_q[$];
  logic [7:0] last = 8'h00;
  logic       prev_valid = 1'b0;
  int n_cmp = 0, n_err = 0, n_valid = 0, n_exp_valid = 0;

  always #10 clk = ~clk;

  uart_receiver dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .RX_EN(RX_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // frame: start, d LSB first, even parity (optionally wrong), stop; optional
  // 20-clk low pulse inside D0 beginning glitch clocks into the bit
  task automatic send(input logic [7:0] d, input bit par_ok, input bit stop, input int glitch);
    logic [10:0] f;
    bit good;
    f = {stop, (^d) ^ !par_ok, d, 1'b0};
`ifdef UART_RX_NOISE_CHECK_EN
    good = par_ok && stop && glitch < 0;
`else
    good = par_ok && stop;
`endif
    if (good) begin
      exp_q.push_back(d);
      n_exp_valid++;
      last = d;
    end
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < BIT; j++) begin
        RxD = f[i] & !(i == 1 && j >= glitch && j < glitch + 20);
        @(negedge clk);
      end
    RxD = 1'b1;
  endtask

  always @(negedge clk) begin
    if (Rx_VALID) begin
      n_valid++;
      n_cmp++;
      assert (exp_q.size() > 0 && Rx_DATA === exp_q[0]) else begin
        n_err++;
        $error("FAIL rx_byte: observed %0h expected %0h", Rx_DATA, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      n_cmp++;
      assert (!prev_valid) else begin
        n_err++;
        $error("FAIL valid_width: observed >1 clk expected 1 clk");
      end
    end
    prev_valid = Rx_VALID;
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_data", Rx_DATA, 8'h00);
    chk("rst_valid", 8'(Rx_VALID), 8'h0);
    chk("rst_perr", 8'(Rx_PERROR), 8'h0);
    chk("rst_ferr", 8'(Rx_FERROR), 8'h0);
    chk("rst_state", 8'(dut.r_state), 8'(IDLE));
    reset = 1'b1;
    RX_EN = 1'b1;
    idle(BIT);
    send(8'h85, 1, 1, -100);
    idle(BIT);
    chk("good_data", Rx_DATA, 8'h85);
    chk("good_perr", 8'(Rx_PERROR), 8'h0);
    chk("good_ferr", 8'(Rx_FERROR), 8'h0);
    chk("good_cnt", 8'(n_valid), 8'(n_exp_valid));
    send(8'h85, 0, 1, -100);
    idle(BIT);
    chk("par_perr", 8'(Rx_PERROR), 8'h1);
    chk("par_ferr", 8'(Rx_FERROR), 8'h0);
    chk("par_data", Rx_DATA, 8'h85);
    chk("par_cnt", 8'(n_valid), 8'(n_exp_valid));
    send(8'h3C, 1, 0, -100);
    idle(BIT);
    chk("frm_ferr", 8'(Rx_FERROR), 8'h1);
    chk("frm_perr", 8'(Rx_PERROR), 8'h0);
    chk("frm_data", Rx_DATA, 8'h85);
    RX_EN = 1'b0;
    idle(BIT);
    chk("dis_ferr", 8'(Rx_FERROR), 8'h1);
    chk("dis_data", Rx_DATA, 8'h85);
    RX_EN = 1'b1;
    idle(10);
    send(8'h5A, 1, 1, -100);
    idle(BIT);
    chk("recov_data", Rx_DATA, 8'h5A);
    chk("recov_ferr", 8'(Rx_FERROR), 8'h0);
    chk("recov_cnt", 8'(n_valid), 8'(n_exp_valid));
    send(8'hC3, 1, 1, -100);
    send(8'h01, 1, 1, -100);
    idle(BIT);
    chk("b2b_data", Rx_DATA, 8'h01);
    chk("b2b_cnt", 8'(n_valid), 8'(n_exp_valid));
    RxD = 1'b0;
    repeat (81) @(negedge clk);
    idle(2 * BIT);
    chk("glitch_cnt", 8'(n_valid), 8'(n_exp_valid));
    chk("glitch_state", 8'(dut.r_state), 8'(IDLE));
    chk("glitch_ferr", 8'(Rx_FERROR), 8'h0);
    chk("glitch_perr", 8'(Rx_PERROR), 8'h0);
    // restart the tick divider so the D0 pulse lands on sample tick 9 only
    baud_select = 3'b110;
    @(negedge clk);
    baud_select = 3'b111;
    send(8'h85, 1, 1, 258);
    idle(BIT);
`ifdef UART_RX_NOISE_CHECK_EN
    chk("noise_ferr", 8'(Rx_FERROR), 8'h1);
`else
    chk("noise_ferr", 8'(Rx_FERROR), 8'h0);
`endif
    chk("noise_data", Rx_DATA, last);
    chk("noise_cnt", 8'(n_valid), 8'(n_exp_valid));
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    RxD = 1'b1;
    repeat (BIT) @(negedge clk);
    RxD = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    RX_EN = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_state", 8'(dut.r_state), 8'(IDLE));
    idle(8 * BIT);
    RX_EN = 1'b1;
    idle(BIT);
    chk("abort_cnt", 8'(n_valid), 8'(n_exp_valid));
    chk("abort_data", Rx_DATA, last);
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    RxD = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmid_data", Rx_DATA, 8'h00);
    chk("rmid_valid", 8'(Rx_VALID), 8'h0);
    chk("rmid_perr", 8'(Rx_PERROR), 8'h0);
    chk("rmid_ferr", 8'(Rx_FERROR), 8'h0);
    @(negedge clk);
    reset = 1'b1;
    idle(BIT);
    send(8'hA5, 1, 1, -100);
    idle(BIT);
    chk("final_data", Rx_DATA, 8'hA5);
    chk("final_cnt", 8'(n_valid), 8'(n_exp_valid));
    chk("queue_empty", 8'(exp_q.size()), 8'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: system clock, 50 MHz nominal; all logic on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `baud_select`, input, 3 bits: baud rate code.
REQ-004 SHALL have port `RX_EN`, input, 1 bit: receiver enable.
REQ-005 SHALL have port `RxD`, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port `Rx_DATA`, output, 8 bits: last received byte.
REQ-007 SHALL have port `Rx_VALID`, output, 1 bit: one-cycle pulse per error-free frame.
REQ-008 SHALL have port `Rx_PERROR`, output, 1 bit: parity error flag.
REQ-009 SHALL have port `Rx_FERROR`, output, 1 bit: framing error flag.

Function
REQ-010 SHALL generate a sample tick at 16x the baud rate, with divider = round(50e6/(16*baud)):
- 000=300 (10417), 001=1200 (2604), 010=4800 (651), 011=9600 (326)
- 100=19200 (163), 101=38400 (81), 110=57600 (54), 111=115200 (27)
REQ-011 SHALL restart the tick divider when baud_select changes.
REQ-012 SHALL pass RxD through a 2-flop synchronizer before any use.
REQ-013 SHALL use the frame format: start (0), 8 data bits LSB first, even parity bit, 1 stop bit (1).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, counting 16 ticks per bit.
REQ-015 IDLE -> START SHALL occur on a synchronized falling edge of RxD while RX_EN=1.
REQ-016 In START, SHALL check the line at tick 8; if RxD=1 (glitch), SHALL return to IDLE with no flag.
REQ-017 SHALL decide each bit value by majority of the samples at ticks 7, 8 and 9.
REQ-018 SHALL assemble data with LSB first; serial 1,0,1,0,0,0,0,1 SHALL yield Rx_DATA=8'h85.
REQ-019 Rx_PERROR SHALL be set when the parity bit differs from the XOR of the 8 data bits.
REQ-020 Rx_FERROR SHALL be set when the stop bit is decided as 0.
REQ-021 On completion of the stop bit, if neither error is set, the block SHALL:
- load Rx_DATA;
- pulse Rx_VALID high for exactly 1 clk.
REQ-022 Rx_DATA SHALL hold its value until the next valid frame; an errored frame SHALL leave Rx_DATA unchanged.
REQ-023 Error flags SHALL stay set until the next start-bit detection, which clears both.
REQ-024 A frame with both errors SHALL assert both flags.
REQ-025 On completion of the stop bit, the block SHALL return to IDLE.
REQ-026 A start bit SHALL be accepted on the tick following a stop bit (back-to-back frames).
REQ-027 RX_EN=0 SHALL force IDLE at the next clk, abort any frame in progress, and produce no Rx_VALID.
REQ-028 RX_EN=0 SHALL NOT clear Rx_DATA or the error flags.

Reset
REQ-029 With reset=0, the block SHALL go asynchronously to this state:
- Rx_DATA=0, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0;
- state IDLE, counters 0;
- synchronizer flops at 1.
REQ-030 A reset asserted mid-frame SHALL discard the frame.

Configuration
REQ-031 Macro UART_RX_NOISE_CHECK_EN SHALL control noise detection as follows:
- Defined: any bit (start, data, parity or stop) whose three mid samples (ticks 7, 8, 9) disagree SHALL also set Rx_FERROR and suppress Rx_VALID.
- Undefined: majority vote only; noise SHALL never set a flag.

Structure
REQ-032 A shared package uart_pkg SHALL hold:
- the state enum;
- the baud divider constant table;
- constants TICKS_PER_BIT=16 and DATA_BITS=8.
REQ-033 A sub-module uart_baud_gen (inputs clk, reset, baud_select; output sample_tick) SHALL produce the 16x tick.
REQ-034 The FSM and datapath SHALL reside in uart_receiver.

Verification
REQ-035 Normal frame: baud_select=111, RxD = 0 | 1,0,1,0,0,0,0,1 | 1 | 1 -> Rx_DATA=8'h85, one 1-clk Rx_VALID pulse, both error flags 0.
REQ-036 Parity error: same frame with parity bit 0 -> Rx_PERROR=1, Rx_VALID stays 0, Rx_DATA unchanged.
REQ-037 Framing error: stop bit 0 -> Rx_FERROR=1, no Rx_VALID; next good frame clears the flag and pulses Rx_VALID.
REQ-038 Glitch on idle line: RxD low for 3 ticks -> no frame received, no flags.
REQ-039 Noise (UART_RX_NOISE_CHECK_EN defined): D0 low only at tick 9 -> Rx_FERROR=1.
REQ-040 RX_EN deasserted mid-frame -> FSM in IDLE, no Rx_VALID; reset asserted mid-frame -> all outputs 0 immediately.
